// File: rtl/io_ctrl.sv
// Bus-attached board I/O block: LED and 7-segment registers with per-digit enable/blink,
// plus a PS/2 scan-code FIFO with sticky overflow, all behind a small word register map.
module io_ctrl #(
  parameter int N_LED      = 10,
  parameter int N_SEG      = 6,
  parameter int BLINK_DIV  = 25000000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic [2:0]           bus_addr,
  input  logic                 bus_wren,
  input  logic [31:0]          bus_wdata,
  input  logic                 bus_rden,
  output logic [31:0]          bus_rdata,
  output logic                 bus_rvalid,
  input  logic                 kbd_valid,
  input  logic [7:0]           kbd_code,
  output logic [N_LED-1:0]     led_out,
  output logic [7*N_SEG-1:0]   seg_out
);

  localparam int PW = $clog2(BLINK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(BLINK_DIV - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [2:0] A_LED  = 3'd0;
  localparam logic [2:0] A_SEGV = 3'd1;
  localparam logic [2:0] A_SEGE = 3'd2;
  localparam logic [2:0] A_STAT = 3'd3;
  localparam logic [2:0] A_DATA = 3'd4;

  logic [N_LED-1:0]   led_reg;
  logic [4*N_SEG-1:0] seg_val;
  logic [N_SEG-1:0]   seg_en;
  logic [N_SEG-1:0]   blink_en;
  logic [PW-1:0]      pre;
  logic               phase;

  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      cnt;
  logic               ovf;

  logic               fifo_empty;
  logic               fifo_full;
  logic               pop;
  logic               push;
  logic               drop;
  logic               wr_hit_stat;
  logic [31:0]        rd_mux;
  logic [7*N_SEG-1:0] seg_nxt;
  logic               unused_wdata;

  assign unused_wdata = ^bus_wdata;

  // Bus protocol: bus_wren and bus_rden are single-cycle strobes with no back-pressure.
  // A read strobe is always answered by a one-cycle bus_rvalid pulse on the next cycle,
  // carrying the register value as it stood before any same-edge write or FIFO push.
  assign fifo_empty  = (cnt == '0);
  assign fifo_full   = (cnt == DEPTH_C);
  assign pop         = bus_rden && (bus_addr == A_DATA) && !fifo_empty;
  assign push        = kbd_valid && (!fifo_full || pop);
  assign drop        = kbd_valid && fifo_full && !pop;
  assign wr_hit_stat = bus_wren && (bus_addr == A_STAT) && bus_wdata[2];

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    rd_mux = '0;
    case (bus_addr)
      A_LED:  rd_mux = 32'(led_reg);
      A_SEGV: rd_mux = 32'(seg_val);
      A_SEGE: rd_mux = 32'(seg_en) | (32'(blink_en) << 8);
      A_STAT: rd_mux = {16'h0, 8'(cnt), 5'h0, ovf, fifo_full, !fifo_empty};
      A_DATA: rd_mux = fifo_empty ? 32'h0 : {24'h0, fifo_mem[rd_ptr]};
      default: rd_mux = '0;
    endcase
  end

  always_comb begin
    seg_nxt = '0;
    for (int i = 0; i < N_SEG; i++) begin
      if (!seg_en[i] || (blink_en[i] && phase))
        seg_nxt[7*i +: 7] = 7'h7F;
      else
        seg_nxt[7*i +: 7] = hex7(seg_val[4*i +: 4]);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      led_reg  <= '0;
      seg_val  <= '0;
      seg_en   <= '1;
      blink_en <= '0;
    end else if (bus_wren) begin
      case (bus_addr)
        A_LED:  led_reg <= bus_wdata[N_LED-1:0];
        A_SEGV: seg_val <= bus_wdata[4*N_SEG-1:0];
        A_SEGE: begin
          seg_en   <= bus_wdata[N_SEG-1:0];
          blink_en <= bus_wdata[8 +: N_SEG];
        end
        default: ;
      endcase
    end
  end

  // Free-running blink timebase; register writes never disturb it.
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      pre   <= '0;
      phase <= 1'b0;
    end else if (pre == PRE_MAX) begin
      pre   <= '0;
      phase <= ~phase;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push)
      fifo_mem[wr_ptr] <= kbd_code;
  end

  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      // A drop on the same edge as a clear leaves overflow set: the newer event wins.
      if (drop)
        ovf <= 1'b1;
      else if (wr_hit_stat)
        ovf <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      bus_rvalid <= 1'b0;
      bus_rdata  <= '0;
      led_out    <= '0;
      seg_out    <= {N_SEG{7'h7F}};
    end else begin
      bus_rvalid <= bus_rden;
      bus_rdata  <= bus_rden ? rd_mux : 32'h0;
      led_out    <= led_reg;
      seg_out    <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_io_ctrl.sv
// Directed bench for io_ctrl: a register-level model predicts every output each cycle,
// and hand-computed literals pin the model on the key scenarios.
module tb_io_ctrl;
  localparam int N_LED = 10;
  localparam int N_SEG = 6;
  localparam int BLINK_DIV = 4;
  localparam int DEPTH = 8;

  logic              sys_clk = 1'b0;
  logic              rst;
  logic [2:0]        bus_addr;
  logic              bus_wren;
  logic [31:0]       bus_wdata;
  logic              bus_rden;
  logic [31:0]       bus_rdata;
  logic              bus_rvalid;
  logic              kbd_valid;
  logic [7:0]        kbd_code;
  logic [N_LED-1:0]  led_out;
  logic [7*N_SEG-1:0] seg_out;

  io_ctrl #(.N_LED(N_LED), .N_SEG(N_SEG), .BLINK_DIV(BLINK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk), .rst(rst), .bus_addr(bus_addr), .bus_wren(bus_wren),
    .bus_wdata(bus_wdata), .bus_rden(bus_rden), .bus_rdata(bus_rdata),
    .bus_rvalid(bus_rvalid), .kbd_valid(kbd_valid), .kbd_code(kbd_code),
    .led_out(led_out), .seg_out(seg_out)
  );

  // ---------------- clock / reset ----------------
  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [7:0]  exp_q [$];
  logic [N_LED-1:0]   m_led;
  logic [4*N_SEG-1:0] m_val;
  logic [N_SEG-1:0]   m_en, m_blink;
  bit                 m_ovf;
  int                 m_tick;
  logic [N_LED-1:0]   e_led;
  logic [7*N_SEG-1:0] e_seg;
  logic               e_rvalid;
  logic [31:0]        e_rdata;

  always @(posedge sys_clk) begin
    int sz;
    bit ph, do_pop, was_full;
    if (!rst) begin
      m_led = '0; m_val = '0; m_en = '1; m_blink = '0; m_ovf = 0; m_tick = 0;
      exp_q.delete();
      e_led = '0; e_seg = {N_SEG{7'h7F}}; e_rvalid = 0; e_rdata = '0;
    end else begin
      ph = ((m_tick / BLINK_DIV) % 2) == 1;
      m_tick++;
      e_led = m_led;
      for (int i = 0; i < N_SEG; i++)
        e_seg[7*i +: 7] = (!m_en[i] || (m_blink[i] && ph)) ? 7'h7F : hex_tab[m_val[4*i +: 4]];
      sz = exp_q.size();
      do_pop = 0;
      e_rvalid = bus_rden;
      e_rdata = '0;
      if (bus_rden) begin
        case (bus_addr)
          3'd0: e_rdata = 32'(m_led);
          3'd1: e_rdata = 32'(m_val);
          3'd2: e_rdata = 32'(m_en) + 32'(m_blink) * 256;
          3'd3: e_rdata = 32'((sz != 0 ? 1 : 0) + (sz == DEPTH ? 2 : 0) + (m_ovf ? 4 : 0) + sz * 256);
          3'd4: if (sz != 0) begin e_rdata = 32'(exp_q[0]); do_pop = 1; end
          default: e_rdata = '0;
        endcase
      end
      if (bus_wren) begin
        case (bus_addr)
          3'd0: m_led = bus_wdata[N_LED-1:0];
          3'd1: m_val = bus_wdata[4*N_SEG-1:0];
          3'd2: begin m_en = bus_wdata[N_SEG-1:0]; m_blink = bus_wdata[8 +: N_SEG]; end
          3'd3: if (bus_wdata[2]) m_ovf = 0;
          default: ;
        endcase
      end
      was_full = (sz == DEPTH);
      if (do_pop) void'(exp_q.pop_front());
      if (kbd_valid) begin
        if (!was_full || do_pop) exp_q.push_back(kbd_code);
        else m_ovf = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge sys_clk) begin
    if (chk_en) begin
      chk("cyc_led", 64'(led_out), 64'(e_led));
      chk("cyc_seg", 64'(seg_out), 64'(e_seg));
      chk("cyc_rvalid", 64'(bus_rvalid), 64'(e_rvalid));
      chk("cyc_rdata", 64'(bus_rdata), 64'(e_rdata));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus_addr = a; bus_wdata = d; bus_wren = 1;
    cyc();
    bus_wren = 0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bus_addr = a; bus_rden = 1;
    cyc();
    bus_rden = 0;
    chk("rd_rvalid", 64'(bus_rvalid), 64'd1);
    d = bus_rdata;
  endtask

  task automatic push(input logic [7:0] c);
    kbd_code = c; kbd_valid = 1;
    cyc();
    kbd_valid = 0;
  endtask

  function automatic logic [6:0] digit(input int i);
    return seg_out[7*i +: 7];
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "timeout");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [31:0] d;
    int n_on, n_off;
    logic [6:0] exp_dig [6] = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};

    rst = 0; bus_addr = 0; bus_wren = 0; bus_wdata = 0; bus_rden = 0;
    kbd_valid = 0; kbd_code = 0;
    cyc();
    chk_en = 1;
    chk("reset_led", 64'(led_out), 64'h0);
    chk("reset_seg", 64'(seg_out), 64'(42'h3FF_FFFF_FFFF));
    chk("reset_rvalid", 64'(bus_rvalid), 64'h0);
    rst = 1;
    chk("pre_first_cycle_seg0", 64'(digit(0)), 64'h7F);
    cyc();
    chk("post_reset_seg0", 64'(digit(0)), 64'h40);

    // LED and digit values; 0x123456 puts 6 in digit0 through 1 in digit5
    wr(3'd0, 32'h2A5);
    wr(3'd1, 32'h0012_3456);
    cyc();
    chk("led_2a5", 64'(led_out), 64'h2A5);
    for (int i = 0; i < 6; i++) chk($sformatf("digit%0d", i), 64'(digit(i)), 64'(exp_dig[i]));
    wr(3'd0, 32'hFFFF_FFFF);
    rd(3'd0, d);
    chk("led_upper_ignored", 64'(d), 64'h3FF);
    rd(3'd1, d);
    chk("segval_read", 64'(d), 64'h0012_3456);

    // Digit0 disabled with blink set stays dark
    wr(3'd2, 32'h0000_013E);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("dig0_disabled", 64'(digit(0)), 64'h7F);
    end
    rd(3'd2, d);
    chk("segen_read", 64'(d), 64'h13E);

    // Digit0 enabled and blinking: 16 cycles hold exactly 8 on and 8 off
    wr(3'd2, 32'h0000_0101);
    cyc();
    n_on = 0; n_off = 0;
    for (int i = 0; i < 16; i++) begin
      if (digit(0) == 7'h02) n_on++;
      if (digit(0) == 7'h7F) n_off++;
      chk("others_dark", 64'(seg_out[41:7]), 64'(35'h7_FFFF_FFFF));
      cyc();
    end
    chk("blink_on_count", 64'(n_on), 64'd8);
    chk("blink_off_count", 64'(n_off), 64'd8);

    // FIFO basic push/pop
    push(8'h1C); push(8'h32); push(8'h21);
    rd(3'd3, d); chk("stat_3", 64'(d), 64'h301);
    rd(3'd4, d); chk("pop_1c", 64'(d), 64'h1C);
    rd(3'd4, d); chk("pop_32", 64'(d), 64'h32);
    rd(3'd4, d); chk("pop_21", 64'(d), 64'h21);
    rd(3'd4, d); chk("pop_empty", 64'(d), 64'h0);
    rd(3'd3, d); chk("stat_empty", 64'(d), 64'h0);

    // Overflow: 9 pushes into 8 entries, then clear the sticky bit
    for (int i = 0; i < 9; i++) push(8'(8'h10 + i));
    rd(3'd3, d); chk("stat_overflow", 64'(d), 64'h807);
    wr(3'd3, 32'h0000_0004);
    rd(3'd3, d); chk("stat_ovf_cleared", 64'(d), 64'h803);

    // Full FIFO: push and pop on the same edge
    kbd_code = 8'h55; kbd_valid = 1; bus_addr = 3'd4; bus_rden = 1;
    cyc();
    kbd_valid = 0; bus_rden = 0;
    chk("full_pushpop_data", 64'(bus_rdata), 64'h10);
    rd(3'd3, d); chk("full_pushpop_stat", 64'(d), 64'h803);
    for (int i = 0; i < 8; i++) begin
      rd(3'd4, d);
      chk("drain", 64'(d), (i < 7) ? 64'(8'h11 + i) : 64'h55);
    end
    rd(3'd3, d); chk("stat_drained", 64'(d), 64'h0);

    // Empty FIFO: push and read on the same edge
    kbd_code = 8'h77; kbd_valid = 1; bus_addr = 3'd4; bus_rden = 1;
    cyc();
    kbd_valid = 0; bus_rden = 0;
    chk("empty_pushread_data", 64'(bus_rdata), 64'h0);
    rd(3'd3, d); chk("empty_pushread_stat", 64'(d), 64'h101);
    rd(3'd4, d); chk("empty_pushread_pop", 64'(d), 64'h77);

    // Unmapped addresses
    wr(3'd5, 32'hDEAD_BEEF);
    for (int a = 5; a < 8; a++) begin
      rd(3'(a), d); chk("unmapped_read", 64'(d), 64'h0);
    end

    // Reset mid-operation with codes queued and a read pending
    push(8'hA1); push(8'hA2); push(8'hA3);
    rst = 0; bus_addr = 3'd4; bus_rden = 1;
    cyc();
    rst = 1; bus_rden = 0;
    chk("midreset_rvalid", 64'(bus_rvalid), 64'h0);
    chk("midreset_seg", 64'(seg_out), 64'(42'h3FF_FFFF_FFFF));
    chk("midreset_led", 64'(led_out), 64'h0);
    cyc();
    chk("midreset_seg0_after", 64'(digit(0)), 64'h40);
    rd(3'd3, d); chk("midreset_stat", 64'(d), 64'h0);
    rd(3'd2, d); chk("midreset_segen", 64'(d), 64'h3F);

    cyc(); cyc();
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
